// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter slice.
// Holds the default geometry of a line transfer, the arbiter FSM state
// encoding and the requester identifiers used by the picker and the top.
package mem_pkg;

    localparam int BURST_LEN_DEFAULT = 8;
    localparam int ADDR_W_DEFAULT    = 64;
    localparam int DATA_W_DEFAULT    = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } requester_e;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker.
// Ports:
//   i_req, d_req : pending requests from icache and dcache
//   last         : requester served by the previous transaction
//   winner       : requester to grant; only meaningful when a request is up
module mem_arb_rr
    import mem_pkg::*;
(
    input  logic       i_req,
    input  logic       d_req,
    input  requester_e last,
    output requester_e winner
);

    always_comb begin
        winner = REQ_D;
        if (i_req && d_req) begin
            // On a tie the side that was not served last takes the grant.
            winner = (last == REQ_I) ? REQ_D : REQ_I;
        end else if (i_req) begin
            winner = REQ_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one burst memory port between an icache (refill only)
// and a dcache (refill or writeback).
// Ports:
//   clk, reset                 : clock, asynchronous active-low reset
//   i_req/i_addr               : icache request and line address
//   i_rdata/i_rvalid/i_done    : icache read beat, strobe, completion pulse
//   d_req/d_we/d_addr/d_wdata  : dcache request, direction, address, write beat
//   d_rdata/d_rvalid           : dcache read beat and strobe
//   d_wnext/d_done             : write beat consumed, completion pulse
//   m_req/m_we/m_addr/m_wdata  : memory address phase and write data
//   m_ack/m_beat/m_rdata       : memory address accept, beat strobe, read data
//   i_busy/d_busy              : requester pending or being served
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int BURST_LEN = BURST_LEN_DEFAULT,
    parameter int ADDR_W    = ADDR_W_DEFAULT,
    parameter int DATA_W    = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rvalid,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    output logic              d_wnext,
    output logic              d_done,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ack,
    input  logic              m_beat,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              i_busy,
    output logic              d_busy
);

    localparam int                CNT_W     = $clog2(BURST_LEN) + 1;
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);

    arb_state_e        state;
    requester_e        winner_q;
    requester_e        last_q;
    requester_e        pick;
    logic [CNT_W-1:0]  cnt_q;

    logic burst_beat;
    logic rd_beat;
    logic active;

    mem_arb_rr u_rr (
        .i_req  (i_req),
        .d_req  (d_req),
        .last   (last_q),
        .winner (pick)
    );

    // Winner, address and direction are captured at grant and held until
    // DONE, so requester inputs moving mid-transaction have no effect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            winner_q <= REQ_I;
            last_q   <= REQ_I;
            cnt_q    <= '0;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            i_done   <= 1'b0;
            d_done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        winner_q <= pick;
                        m_we     <= (pick == REQ_D) && d_we;
                        m_addr   <= (pick == REQ_D) ? d_addr : i_addr;
                        m_req    <= 1'b1;
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_ack) begin
                        cnt_q <= '0;
                        m_req <= 1'b0;
                        state <= BURST;
                    end
                end
                BURST: begin
                    if (m_beat) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_BEAT) begin
                            i_done <= (winner_q == REQ_I);
                            d_done <= (winner_q == REQ_D);
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    i_done <= 1'b0;
                    d_done <= 1'b0;
                    last_q <= winner_q;
                    m_we   <= 1'b0;
                    m_addr <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Beat routing is combinational so read data reaches the cache in the
    // same cycle as m_beat; m_we is only ever set for a dcache writeback.
    assign active     = (state != IDLE);
    assign burst_beat = (state == BURST) && m_beat;
    assign rd_beat    = burst_beat && !m_we;

    assign i_rvalid = rd_beat && (winner_q == REQ_I);
    assign d_rvalid = rd_beat && (winner_q == REQ_D);
    assign i_rdata  = i_rvalid ? m_rdata : '0;
    assign d_rdata  = d_rvalid ? m_rdata : '0;
    assign d_wnext  = burst_beat && m_we;
    assign m_wdata  = m_we ? d_wdata : '0;

    assign i_busy = i_req || (active && (winner_q == REQ_I));
    assign d_busy = d_req || (active && (winner_q == REQ_D));

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter BURST_LEN, default 8, beats per line transfer.
REQ-002 Parameter ADDR_W, default 64, address width.
REQ-003 Parameter DATA_W, default 64, beat width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 i_req  in  1  icache refill request; held until i_done.
REQ-007 i_addr  in  ADDR_W  icache line address.
REQ-008 i_rdata/i_rvalid  out  DATA_W/1  icache read beat and its strobe.
REQ-009 i_done  out  1  one-cycle pulse on icache transaction completion.
REQ-010 d_req  in  1  dcache request; held until d_done.
REQ-011 d_we  in  1  dcache writeback (1) or refill (0).
REQ-012 d_addr/d_wdata  in  ADDR_W/DATA_W  dcache line address and current write beat.
REQ-013 d_rdata/d_rvalid  out  DATA_W/1  dcache read beat and its strobe.
REQ-014 d_wnext  out  1  current d_wdata beat consumed; dcache advances.
REQ-015 d_done  out  1  one-cycle pulse on dcache transaction completion.
REQ-016 m_req/m_we/m_addr/m_wdata  out  1/1/ADDR_W/DATA_W  shared memory port.
REQ-017 m_ack  in  1  memory accepted the address phase.
REQ-018 m_beat/m_rdata  in  1/DATA_W  beat transferred; read data.
REQ-019 i_busy/d_busy  out  1/1  requester has a pending or active transaction; feeds stall logic.

Function
REQ-020 FSM states: IDLE, ADDR, BURST, DONE.
REQ-021 IDLE: with any request, latch the winner, its address and its d_we; go to ADDR on the next edge.
REQ-022 Arbitration: a single requester wins. If both request, the winner is the requester not served last (round-robin). After reset, dcache wins the first tie.
REQ-023 ADDR: drive m_req=1 with the latched m_addr/m_we; on m_ack, clear the beat counter, deassert m_req and go to BURST.
REQ-024 BURST: each m_beat increments the beat counter.
- Read: m_rdata routed to the winner's rdata with rvalid in the same cycle (combinational, zero latency).
- Write: d_wnext=1 in that cycle.
REQ-025 Counter width is clog2(BURST_LEN)+1. When m_beat arrives with count==BURST_LEN-1, go to DONE.
REQ-026 DONE: pulse the winner's done for exactly one cycle, record last-served, return to IDLE. Earliest next grant is one cycle later.
REQ-027 m_wdata = d_wdata passthrough while a dcache write is active; otherwise 0.
REQ-028 Winner, address and direction are frozen from grant to done. Requester inputs that change or drop mid-transaction are ignored and the burst completes.
REQ-029 i_busy = i_req OR (icache is active winner); d_busy likewise.
REQ-030 m_beat outside BURST is ignored; m_ack outside ADDR is ignored.
REQ-031 rvalid, done and d_wnext are never asserted to the non-winning requester.

Reset
REQ-032 Asserting reset (low) at any time, including mid-burst, forces IDLE immediately.
REQ-033 On reset: beat counter 0; last-served = icache; every output 0. The in-flight memory transaction is abandoned.
REQ-034 After reset deasserts, arbitration resumes from IDLE on the first rising edge.

Structure
REQ-035 A shared package mem_pkg holds:
- BURST_LEN, ADDR_W and DATA_W defaults;
- typedef arb_state_e (IDLE/ADDR/BURST/DONE);
- typedef requester_e (REQ_I/REQ_D).
REQ-036 A single sub-module, mem_arb_rr, holds the 2-way round-robin picker (inputs: i_req, d_req, last; output: winner).
REQ-037 No other sub-modules. Single clock domain; no latches.

Verification
REQ-038 Scenario: d_req=1, d_we=0, addr 0x1000 alone; m_ack one cycle after m_req; 8 m_beat. Required response: d_rvalid 8 times with matching data, d_done one cycle after the 8th beat, i_* outputs silent.
REQ-039 Scenario: i_req and d_req raised in the same cycle after reset. Required response: dcache served first, then icache. Repeat the tie: dcache served first again.
REQ-040 Scenario: dcache write of 8 beats, d_wdata=beat index, m_beat every other cycle. Required response: m_wdata sequence 0..7, d_wnext pulsed 8 times, d_done once.
REQ-041 Scenario: reset asserted after the 3rd beat of an icache refill. Required response: outputs 0 within the same cycle, state IDLE, no i_done. A new i_req after reset is granted normally.
REQ-042 Scenario: i_req dropped mid-burst. Required response: all 8 beats still delivered and i_done pulses.
REQ-043 Scenario: m_beat pulsed while in IDLE or ADDR. Required response: no rvalid, no d_wnext, counter unchanged.
